// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter. It keeps fixed-length bursts and locked sequences
// intact, and parks the bus on DEFAULT_MGR when no manager is requesting.
module ahb_arbiter #(
  parameter int NUM_MGR     = 4,
  parameter int DEFAULT_MGR = 0,
  parameter int MW          = $clog2(NUM_MGR)
) (
  input  logic               Hclk,
  input  logic               Hresetn,
  input  logic [NUM_MGR-1:0] Hbusreq,
  input  logic [NUM_MGR-1:0] Hlock,
  input  logic [1:0]         Htrans,
  input  logic [2:0]         Hburst,
  input  logic               Hready,
  output logic [NUM_MGR-1:0] Hgrant,
  output logic [MW-1:0]      Hmaster,
  output logic [MW-1:0]      Hmaster_d,
  output logic               Hmastlock
);

  typedef enum logic [1:0] {
    ST_PARK  = 2'd0,
    ST_OWN   = 2'd1,
    ST_BURST = 2'd2,
    ST_LOCK  = 2'd3
  } state_e;

  localparam logic [1:0]         TRANS_NONSEQ = 2'd2;
  localparam logic [1:0]         TRANS_SEQ    = 2'd3;
  localparam logic [MW-1:0]      DEF_IDX      = MW'(DEFAULT_MGR);
  localparam logic [NUM_MGR-1:0] GRANT_LSB    = NUM_MGR'(1);

  // Remaining SEQ beats after the NONSEQ; SINGLE and INCR never pin the bus.
  function automatic logic [3:0] burst_last_beat(input logic [2:0] hburst);
    logic [3:0] beats;
    case (hburst)
      3'd2, 3'd3: beats = 4'd3;
      3'd4, 3'd5: beats = 4'd7;
      3'd6, 3'd7: beats = 4'd15;
      default:    beats = 4'd0;
    endcase
    return beats;
  endfunction

  // Round-robin search starting one past the last granted requester.
  function automatic logic rr_pick(input  logic [NUM_MGR-1:0] req,
                                   input  logic [MW-1:0]      ptr,
                                   output logic [MW-1:0]      win);
    logic found;
    int   idx;
    found = 1'b0;
    win   = '0;
    for (int i = 1; i <= NUM_MGR; i++) begin
      idx = (int'(ptr) + i) % NUM_MGR;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx[MW-1:0];
      end
    end
    return found;
  endfunction

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [MW-1:0]        ptr_q, ptr_d;
  logic [MW-1:0]        master_q, master_d;
  logic [MW-1:0]        mdph_q, mdph_d;
  logic [NUM_MGR-1:0]   grant_q, grant_d;

  logic                 owner_lock_s;
  logic                 req_any_s;
  logic [MW-1:0]        winner_s;
  logic [3:0]           cnt_nxt_s;

  // Next-state logic: counter update, handover decision and owner selection.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    master_d     = master_q;
    mdph_d       = mdph_q;
    grant_d      = grant_q;
    owner_lock_s = Hlock[master_q];
    req_any_s    = rr_pick(Hbusreq, ptr_q, winner_s);

    case (Htrans)
      TRANS_NONSEQ: cnt_nxt_s = burst_last_beat(Hburst);
      TRANS_SEQ:    cnt_nxt_s = (cnt_q != 4'd0) ? (cnt_q - 4'd1) : 4'd0;
      default:      cnt_nxt_s = cnt_q;
    endcase

    // A non-zero next count means a fixed burst still has beats to go.
    if (Hready) begin
      cnt_d  = cnt_nxt_s;
      mdph_d = master_q;
      if (owner_lock_s) begin
        state_d = ST_LOCK;
      end else if (cnt_nxt_s != 4'd0) begin
        state_d = ST_BURST;
      end else if (req_any_s) begin
        state_d  = ST_OWN;
        master_d = winner_s;
        grant_d  = GRANT_LSB << winner_s;
        ptr_d    = winner_s;
      end else begin
        state_d  = ST_PARK;
        master_d = DEF_IDX;
        grant_d  = GRANT_LSB << DEF_IDX;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers; a wait state (Hready low) holds everything.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q  <= ST_PARK;
      cnt_q    <= 4'd0;
      ptr_q    <= DEF_IDX;
      master_q <= DEF_IDX;
      mdph_q   <= DEF_IDX;
      grant_q  <= GRANT_LSB << DEF_IDX;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      master_q <= master_d;
      mdph_q   <= mdph_d;
      grant_q  <= grant_d;
    end
  end

  assign Hgrant    = grant_q;
  assign Hmaster   = master_q;
  assign Hmaster_d = mdph_q;
  assign Hmastlock = (state_q == ST_LOCK);

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: directed vector table, lock and reset
// sequences, then random traffic against a behavioural reference model.
module tb_ahb_arbiter;

  logic       Hclk = 1'b0;
  logic       Hresetn = 1'b0;
  logic [3:0] Hbusreq = 4'b0000;
  logic [3:0] Hlock = 4'b0000;
  logic [1:0] Htrans = 2'd0;
  logic [2:0] Hburst = 3'd0;
  logic       Hready = 1'b1;
  logic [3:0] Hgrant;
  logic [1:0] Hmaster;
  logic [1:0] Hmaster_d;
  logic       Hmastlock;

  always #5 Hclk = ~Hclk;

  ahb_arbiter #(.NUM_MGR(4), .DEFAULT_MGR(0)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hbusreq(Hbusreq), .Hlock(Hlock),
    .Htrans(Htrans), .Hburst(Hburst), .Hready(Hready), .Hgrant(Hgrant),
    .Hmaster(Hmaster), .Hmaster_d(Hmaster_d), .Hmastlock(Hmastlock)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       ready;
    logic [3:0] g;
    logic [1:0] m;
    logic [1:0] md;
    logic       ml;
  } vec_t;

  vec_t tbl[18];
  int   n_vec = 0;
  int   n_err = 0;

  // reference model state
  int m_owner, m_ptr, m_rem, m_dph;
  bit m_ml;

  function automatic vec_t mk(input logic [3:0] req, input logic [3:0] lock,
                              input logic [1:0] trans, input logic [2:0] burst,
                              input logic ready, input logic [3:0] g,
                              input logic [1:0] m, input logic [1:0] md,
                              input logic ml);
    vec_t v;
    v.req = req; v.lock = lock; v.trans = trans; v.burst = burst; v.ready = ready;
    v.g = g; v.m = m; v.md = md; v.ml = ml;
    return v;
  endfunction

  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] em,
                       input logic [1:0] emd, input logic eml);
    n_vec++;
    if (Hgrant !== eg || Hmaster !== em || Hmaster_d !== emd || Hmastlock !== eml) begin
      n_err++;
      $display("FAIL %s: got grant=%b master=%0d master_d=%0d mastlock=%b, want grant=%b master=%0d master_d=%0d mastlock=%b",
               name, Hgrant, Hmaster, Hmaster_d, Hmastlock, eg, em, emd, eml);
    end
  endtask

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] lock,
                       input logic [1:0] trans, input logic [2:0] burst, input logic ready);
    Hbusreq = req; Hlock = lock; Htrans = trans; Hburst = burst; Hready = ready;
  endtask

  task automatic do_reset();
    drive(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1);
    Hresetn = 1'b0;
    tick();
    Hresetn = 1'b1;
  endtask

  // Rules-level model: advance one clock edge using the current bus inputs.
  task automatic model_step();
    int  beats;
    int  winner;
    bit  owner_locked;
    if (Hready) begin
      owner_locked = Hlock[m_owner];
      m_dph = m_owner;
      m_ml  = owner_locked;
      if (Htrans == 2'd2) begin
        beats = (int'(Hburst) < 2) ? 1 : (1 << (int'(Hburst) / 2 + 1));
        m_rem = beats - 1;
      end else if (Htrans == 2'd3 && m_rem > 0) begin
        m_rem = m_rem - 1;
      end
      if (!owner_locked && m_rem == 0) begin
        winner = -1;
        for (int k = 1; k <= 4; k++)
          if (winner < 0 && Hbusreq[(m_ptr + k) % 4]) winner = (m_ptr + k) % 4;
        if (winner < 0) begin
          m_owner = 0;
        end else begin
          m_owner = winner;
          m_ptr   = winner;
        end
      end
    end
  endtask

  initial begin
    tbl[0]  = mk(4'b0110, 4'b0000, 2'd2, 3'd0, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0);
    tbl[1]  = mk(4'b0110, 4'b0000, 2'd2, 3'd0, 1'b1, 4'b0100, 2'd2, 2'd1, 1'b0);
    tbl[2]  = mk(4'b0110, 4'b0000, 2'd2, 3'd0, 1'b1, 4'b0010, 2'd1, 2'd2, 1'b0);
    tbl[3]  = mk(4'b0110, 4'b0000, 2'd2, 3'd0, 1'b1, 4'b0100, 2'd2, 2'd1, 1'b0);
    tbl[4]  = mk(4'b0010, 4'b0000, 2'd2, 3'd0, 1'b1, 4'b0010, 2'd1, 2'd2, 1'b0);
    tbl[5]  = mk(4'b1010, 4'b0000, 2'd2, 3'd3, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
    tbl[6]  = mk(4'b1010, 4'b0000, 2'd3, 3'd3, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
    tbl[7]  = mk(4'b1010, 4'b0000, 2'd3, 3'd3, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
    tbl[8]  = mk(4'b1010, 4'b0000, 2'd3, 3'd3, 1'b1, 4'b1000, 2'd3, 2'd1, 1'b0);
    tbl[9]  = mk(4'b0010, 4'b0000, 2'd2, 3'd0, 1'b1, 4'b0010, 2'd1, 2'd3, 1'b0);
    tbl[10] = mk(4'b1010, 4'b0000, 2'd2, 3'd3, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
    tbl[11] = mk(4'b1010, 4'b0000, 2'd3, 3'd3, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
    tbl[12] = mk(4'b1010, 4'b0000, 2'd3, 3'd3, 1'b0, 4'b0010, 2'd1, 2'd1, 1'b0);
    tbl[13] = mk(4'b1010, 4'b0000, 2'd3, 3'd3, 1'b0, 4'b0010, 2'd1, 2'd1, 1'b0);
    tbl[14] = mk(4'b1010, 4'b0000, 2'd3, 3'd3, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
    tbl[15] = mk(4'b1010, 4'b0000, 2'd3, 3'd3, 1'b1, 4'b1000, 2'd3, 2'd1, 1'b0);
    tbl[16] = mk(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0001, 2'd0, 2'd3, 1'b0);
    tbl[17] = mk(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0);

    do_reset();
    check("reset", 4'b0001, 2'd0, 2'd0, 1'b0);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].req, tbl[i].lock, tbl[i].trans, tbl[i].burst, tbl[i].ready);
      tick();
      check($sformatf("table[%0d]", i), tbl[i].g, tbl[i].m, tbl[i].md, tbl[i].ml);
    end

    // locked sequence from manager 2 while manager 0 waits
    drive(4'b0100, 4'b0000, 2'd2, 3'd0, 1'b1);
    tick();
    check("lock_grant", 4'b0100, 2'd2, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(4'b0101, 4'b0100, 2'd2, 3'd0, 1'b1);
      tick();
      check($sformatf("lock_hold[%0d]", i), 4'b0100, 2'd2, 2'd2, 1'b1);
    end
    drive(4'b0001, 4'b0000, 2'd2, 3'd0, 1'b1);
    tick();
    check("lock_release", 4'b0001, 2'd0, 2'd2, 1'b0);
    drive(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1);
    tick();
    check("park", 4'b0001, 2'd0, 2'd0, 1'b0);

    // asynchronous reset in the middle of a locked INCR4
    drive(4'b0100, 4'b0000, 2'd2, 3'd0, 1'b1);
    tick();
    check("pre_reset_grant", 4'b0100, 2'd2, 2'd0, 1'b0);
    drive(4'b0100, 4'b0100, 2'd2, 3'd3, 1'b1);
    tick();
    check("pre_reset_burst", 4'b0100, 2'd2, 2'd2, 1'b1);
    #2 Hresetn = 1'b0;
    #1 check("async_reset", 4'b0001, 2'd0, 2'd0, 1'b0);
    #1 Hresetn = 1'b1;
    drive(4'b0010, 4'b0000, 2'd2, 3'd0, 1'b1);
    tick();
    check("post_reset_burst_dropped", 4'b0010, 2'd1, 2'd0, 1'b0);

    // random traffic against the reference model
    do_reset();
    m_owner = 0; m_ptr = 0; m_rem = 0; m_dph = 0; m_ml = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      Hbusreq = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) Hlock[k] = ($urandom_range(0, 7) == 0);
      Htrans = 2'($urandom_range(0, 3));
      Hburst = 3'($urandom_range(0, 7));
      Hready = ($urandom_range(0, 4) != 0);
      model_step();
      tick();
      check($sformatf("random[%0d]", c), 4'(1 << m_owner), 2'(m_owner), 2'(m_dph), m_ml);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin bus arbiter that shares the single AHB address/data path between `NUM_MGR` managers. It sits in front of the manager-side address/control multiplexer and the address decoder. It drives one-hot `Hgrant` and the owner index `Hmaster`, which select the manager whose `Haddr`/`Htrans`/`Hburst` reach the decoder and subordinates. Ownership changes only at legal AHB handover points: fixed bursts are never split, locked sequences are never interrupted, and the bus parks on a default manager when idle.

## Interface
Parameters:
- `NUM_MGR`, default 4: number of managers, 2..16.
- `DEFAULT_MGR`, default 0: parking manager index, must be < `NUM_MGR`.
- `MW`, default `$clog2(NUM_MGR)`: width of the owner index.

Ports:
- `Hclk` input 1: bus clock; all state changes on the rising edge.
- `Hresetn` input 1: asynchronous, active-low reset.
- `Hbusreq` input `NUM_MGR`: per-manager bus request.
- `Hlock` input `NUM_MGR`: per-manager locked-transfer request.
- `Htrans` input 2: muxed bus transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- `Hburst` input 3: muxed bus burst type (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7).
- `Hready` input 1: bus ready; a beat is accepted when `Hready`=1.
- `Hgrant` output `NUM_MGR`: one-hot grant; always exactly one bit set.
- `Hmaster` output `MW`: index of the address-phase owner; always matches `Hgrant`.
- `Hmaster_d` output `MW`: index of the data-phase owner.
- `Hmastlock` output 1: the current address-phase transfer is locked.

## Operation
- Terms:
  - "owner" is the manager whose `Hgrant` bit is set.
  - "accept" means a cycle with `Hready`=1.
- States:
  - PARK: the default manager owns the bus with no active request.
  - OWN: a requesting owner has the bus and the bus is interruptible.
  - BURST: a fixed-length burst is in progress.
  - LOCK: the owner holds `Hlock`.
- Beat counter, 4 bits:
  - On an accepted NONSEQ, load beats−1: 3 for WRAP4/INCR4, 7 for WRAP8/INCR8, 15 for WRAP16/INCR16, 0 for SINGLE/INCR.
  - If the loaded value is >0, enter BURST.
  - On an accepted SEQ, decrement; never decrement below 0.
  - BUSY and IDLE hold the counter.
- A handover is allowed when all of the following hold: `Hready`=1, the state is not BURST (or the counter is 0 on an accepted SEQ), and the owner's `Hlock`=0.
  - INCR bursts are interruptible at any accepted beat.
- Selection at a handover point:
  - Search `Hbusreq` round-robin, starting at (last granted requester + 1) mod `NUM_MGR`, where the last granted requester is held in the pointer.
  - If the owner still requests and no other manager requests, the owner keeps the bus.
  - If no manager requests, grant `DEFAULT_MGR` and go to PARK.
  - If the winner differs from the current owner, the new grant takes effect on that edge, and the pointer is updated to the winner.
- Transitions:
  - PARK→OWN: any request at a handover point.
  - OWN→BURST: fixed-length NONSEQ accepted.
  - BURST→OWN: last SEQ accepted.
  - Any→LOCK: the owner's `Hlock`=1 at an accept.
  - LOCK→OWN: the owner's `Hlock`=0 at an accept.
  - OWN→PARK: no requests at a handover point.
- `Hmastlock` = registered (owner's `Hlock`), updated on accept.
- `Hmaster_d` loads `Hmaster` on every accept; it holds when `Hready`=0.
- Reset, asynchronous:
  - `Hgrant` = one-hot `DEFAULT_MGR`; `Hmaster` = `Hmaster_d` = `DEFAULT_MGR`.
  - `Hmastlock`=0, counter=0, pointer=`DEFAULT_MGR`, state=PARK.
  - Reset mid-burst abandons the burst.

## Timing
- Request-to-grant latency is 1 cycle when the bus is at a handover point: `Hbusreq` sampled at edge N → `Hgrant`/`Hmaster` valid after edge N.
- During BURST or LOCK, the grant changes on the edge that accepts the final beat.
- `Hready`=0 freezes all state: grant, counter, pointer and `Hmaster_d`.
- Simultaneous requests are resolved by round-robin order in one cycle; no priority skew.
- When the owner drops `Hbusreq` in the same cycle as a fixed-burst NONSEQ, the burst still completes.
- Outputs are fully registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset with `Hresetn`=0 mid-cycle → `Hgrant`=4'b0001, `Hmaster`=0, `Hmastlock`=0; asynchronous, visible before the next edge.
- Managers 1 and 2 request continuously, all SINGLE, `Hready`=1 → grants alternate 1,2,1,2 each cycle; `Hmaster_d` lags `Hmaster` by 1 cycle.
- Manager 1 issues INCR4 (NONSEQ+3 SEQ) while manager 3 requests → `Hgrant` stays 4'b0010 for 4 accepts, then becomes 4'b1000 on the edge of the last SEQ.
- INCR4 with `Hready`=0 for 2 cycles on beat 2 → grant is held; the handover is delayed exactly 2 cycles.
- Manager 2 asserts `Hlock` and `Hbusreq` for 5 SINGLE transfers while manager 0 requests → `Hmastlock`=1 throughout; no handover until `Hlock` drops, then grant goes to 0.
- All `Hbusreq` drop → `Hgrant` returns to `DEFAULT_MGR` one cycle after the handover point, with state PARK.
